// File: rtl/ifetch_prefetch.sv
// rtl/ifetch_prefetch.sv - word prefetch buffer feeding a nibble-packed instruction decoder
module ifetch_prefetch #(
    parameter int                    ADDR_WIDTH   = 16,
    parameter int                    WORD_NIBBLES = 4,
    parameter int                    DEPTH        = 2,
    parameter logic [ADDR_WIDTH-1:0] RESET_ADDR   = '0
) (
    input  logic                    clk,
    input  logic                    reset,
    output logic                    mem_req,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    input  logic                    mem_ack,
    input  logic [4*WORD_NIBBLES-1:0] mem_data,
    input  logic                    suspend,
    input  logic                    jump_valid,
    input  logic [ADDR_WIDTH-1:0]   jump_addr,
    output logic                    insn_valid,
    input  logic                    insn_ready,
    output logic [7:0]              insn,
    output logic                    insn_long,
    output logic [ADDR_WIDTH+2:0]   insn_pc
);
    localparam int              W        = 4 * WORD_NIBBLES;
    localparam int              PW       = $clog2(DEPTH);
    localparam logic [PW:0]     DEPTH_C  = (PW+1)'(DEPTH);
    localparam logic [2:0]      LAST_NIB = 3'(WORD_NIBBLES - 1);
    localparam logic [3:0]      NIBS_C   = 4'(WORD_NIBBLES);

    logic [W-1:0]          word_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
    logic [PW-1:0]         rd_ptr, wr_ptr;
    logic [PW:0]           count;
    logic [2:0]            nib_idx;
    logic                  req_q, discard;
    logic [ADDR_WIDTH-1:0] req_addr, next_addr;

    logic        push, pop, fire, skip, is_long, have_second, head_valid;
    logic [31:0] head_pad;
    logic [3:0]  nib, second, adv, new_pos;

    // A request is raised combinationally when idle so it appears the cycle after an ack
    // or after reset; once raised it is latched in req_q and held until acknowledged.
    assign mem_req  = ~reset & (req_q | (~suspend & (count < DEPTH_C)));
    assign mem_addr = req_q ? req_addr : next_addr;
    assign push     = mem_req & mem_ack & ~discard & ~jump_valid;

    always_comb begin
        head_pad    = 32'(word_mem[rd_ptr]);
        head_valid  = (count != '0);
        nib         = head_pad[{nib_idx, 2'b00} +: 4];
        second      = (nib_idx == LAST_NIB) ? word_mem[rd_ptr + PW'(1)][3:0]
                                            : head_pad[{nib_idx + 3'd1, 2'b00} +: 4];
        is_long     = (nib == 4'hF);
        have_second = (nib_idx != LAST_NIB) | (count > (PW+1)'(1));
        insn_valid  = ~reset & head_valid & (nib != 4'h0) & (~is_long | have_second);
        skip        = head_valid & (nib == 4'h0);
        fire        = insn_valid & insn_ready;
        adv         = skip ? 4'd1 : (fire ? (is_long ? 4'd2 : 4'd1) : 4'd0);
        new_pos     = {1'b0, nib_idx} + adv;
        pop         = (new_pos >= NIBS_C);
        insn        = insn_valid ? (is_long ? {second, 4'hF} : {4'h0, nib}) : 8'h00;
        insn_long   = insn_valid & is_long;
        insn_pc     = insn_valid ? {addr_mem[rd_ptr], nib_idx} : '0;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            word_mem[wr_ptr] <= mem_data;
            addr_mem[wr_ptr] <= mem_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            req_q     <= 1'b0;
            discard   <= 1'b0;
            next_addr <= RESET_ADDR;
            req_addr  <= RESET_ADDR;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            nib_idx   <= 3'd0;
        end else begin
            req_q <= mem_req & ~mem_ack;
            if (mem_req & ~req_q) begin
                req_addr  <= next_addr;
                next_addr <= next_addr + ADDR_WIDTH'(1);
            end
            if (mem_req & mem_ack)
                discard <= 1'b0;
            // Flush; a request still in flight completes on the bus but its word is dropped.
            if (jump_valid) begin
                next_addr <= jump_addr;
                discard   <= mem_req & ~mem_ack;
                rd_ptr    <= '0;
                wr_ptr    <= '0;
                count     <= '0;
                nib_idx   <= 3'd0;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + PW'(1);
                if (pop)
                    rd_ptr <= rd_ptr + PW'(1);
                nib_idx <= pop ? 3'(new_pos - NIBS_C) : new_pos[2:0];
                count   <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
            end
        end
    end
endmodule

// File: tb/tb_ifetch_prefetch.sv
// tb/tb_ifetch_prefetch.sv - randomized bench for ifetch_prefetch against a nibble-stream model
module tb_ifetch_prefetch;
    localparam logic [15:0] RST_A = 16'h0000;

    logic        clk, reset, mem_req, mem_ack, suspend, jump_valid, insn_valid, insn_ready, insn_long;
    logic [15:0] mem_addr, mem_data, jump_addr;
    logic [7:0]  insn;
    logic [18:0] insn_pc;

    ifetch_prefetch #(.ADDR_WIDTH(16), .WORD_NIBBLES(4), .DEPTH(2), .RESET_ADDR(RST_A)) dut (
        .clk(clk), .reset(reset), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
        .mem_data(mem_data), .suspend(suspend), .jump_valid(jump_valid), .jump_addr(jump_addr),
        .insn_valid(insn_valid), .insn_ready(insn_ready), .insn(insn), .insn_long(insn_long),
        .insn_pc(insn_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_vec, n_err, acks, xfers, wait_cnt, lat, fixed_lat;
    logic [15:0] mem [1024];
    logic [17:0] mpos;
    logic [15:0] exp_req_addr, req_addr_q, obs_addr;
    bit          req_seen, hold_pend, obs_req;
    logic [7:0]  hold_insn;
    logic        hold_long;
    logic [18:0] hold_pc;
    logic [15:0] req_log [$];
    logic [27:0] xfer_log [$];
    bit          s_rst, s_susp, s_ready, s_jv;
    logic [15:0] s_ja;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] rand_word();
        logic [15:0] w;
        int r;
        for (int k = 0; k < 4; k++) begin
            r = $urandom_range(0, 15);
            w = {(r < 4) ? 4'h0 : (r < 6) ? 4'hF : 4'($urandom_range(1, 14)), w[15:4]};
        end
        return w;
    endfunction

    function automatic logic [3:0] nib_at(input logic [17:0] p);
        logic [15:0] s;
        s = mem[p[11:2]] >> {p[1:0], 2'b00};
        return s[3:0];
    endfunction

    // Next instruction of the program stream: zeros vanish, 0xF swallows the following nibble.
    task automatic model_next(output logic [7:0] ei, output logic el, output logic [18:0] ep);
        for (int k = 0; k < 8192 && nib_at(mpos) == 4'h0; k++)
            mpos = mpos + 18'd1;
        ep = {mpos[17:2], 1'b0, mpos[1:0]};
        if (nib_at(mpos) == 4'hF) begin
            ei = {nib_at(mpos + 18'd1), 4'hF};
            el = 1'b1;
            mpos = mpos + 18'd2;
        end else begin
            ei = {4'h0, nib_at(mpos)};
            el = 1'b0;
            mpos = mpos + 18'd1;
        end
    endtask

    task automatic cycle();
        logic [7:0]  ei;
        logic        el;
        logic [18:0] ep;
        @(negedge clk);
        reset = s_rst; suspend = s_susp; insn_ready = s_ready;
        jump_valid = s_jv; jump_addr = s_ja;
        mem_ack = 1'b0; mem_data = 16'($urandom);
        #1;
        obs_req = mem_req; obs_addr = mem_addr;
        if (reset) begin
            check("rst_req_valid", 32'({mem_req, insn_valid}), 32'd0);
            check("rst_insn_pc", 32'({insn_long, insn, insn_pc}), 32'd0);
            mem_ack = ($urandom_range(0, 1) == 1);
            mpos = {RST_A, 2'b00}; exp_req_addr = RST_A;
            req_seen = 0; hold_pend = 0;
        end else begin
            if (hold_pend)
                check("hold", 32'({insn_valid, insn_long, insn, insn_pc}),
                      32'({1'b1, hold_long, hold_insn, hold_pc}));
            hold_pend = 0;
            if (req_seen) begin
                check("req_held", 32'({mem_req, mem_addr}), 32'({1'b1, req_addr_q}));
            end else if (mem_req) begin
                check("req_addr", 32'(mem_addr), 32'(exp_req_addr));
                req_log.push_back(mem_addr);
                exp_req_addr = exp_req_addr + 16'd1;
                req_seen = 1; req_addr_q = mem_addr; wait_cnt = 0;
            end
            if (req_seen) begin
                if (wait_cnt >= lat) begin
                    mem_ack = 1'b1; mem_data = mem[mem_addr[9:0]];
                    req_seen = 0; acks++;
                    lat = (fixed_lat >= 0) ? fixed_lat : $urandom_range(0, 2);
                end else begin
                    wait_cnt++;
                end
            end
            if (insn_valid && insn_ready) begin
                model_next(ei, el, ep);
                check("insn", 32'(insn), 32'(ei));
                check("insn_long", 32'(insn_long), 32'(el));
                check("insn_pc", 32'(insn_pc), 32'(ep));
                xfer_log.push_back({insn, insn_long, insn_pc});
                xfers++;
            end else if (insn_valid) begin
                hold_pend = 1; hold_insn = insn; hold_long = insn_long; hold_pc = insn_pc;
            end
            if (jump_valid) begin
                mpos = {jump_addr, 2'b00}; exp_req_addr = jump_addr; hold_pend = 0;
            end
        end
    endtask

    task automatic do_reset();
        s_rst = 1; s_jv = 0;
        repeat (2) cycle();
        s_rst = 0;
    endtask

    logic [27:0] exp_tab [9];
    logic [31:0] v;
    int          x0;
    bit          found;

    initial begin
        n_vec = 0; n_err = 0; acks = 0; xfers = 0; wait_cnt = 0;
        fixed_lat = 1; lat = 1; req_seen = 0; hold_pend = 0;
        reset = 1; suspend = 0; insn_ready = 0; jump_valid = 0; jump_addr = 0;
        mem_ack = 0; mem_data = 0;
        s_rst = 1; s_susp = 0; s_ready = 1; s_jv = 0; s_ja = 0;
        for (int a = 0; a < 1024; a++) mem[a] = rand_word();

        // startup, short, long across a word boundary, noop skip
        mem[0] = 16'h4321; mem[1] = 16'hF321; mem[2] = 16'h0005; mem[3] = 16'h5000;
        exp_tab = '{{8'h01, 1'b0, 16'd0, 3'd0}, {8'h02, 1'b0, 16'd0, 3'd1},
                    {8'h03, 1'b0, 16'd0, 3'd2}, {8'h04, 1'b0, 16'd0, 3'd3},
                    {8'h01, 1'b0, 16'd1, 3'd0}, {8'h02, 1'b0, 16'd1, 3'd1},
                    {8'h03, 1'b0, 16'd1, 3'd2}, {8'h5F, 1'b1, 16'd1, 3'd3},
                    {8'h05, 1'b0, 16'd3, 3'd3}};
        do_reset();
        req_log.delete(); xfer_log.delete();
        cycle();
        check("start_req", 32'({obs_req, obs_addr}), 32'({1'b1, 16'h0000}));
        repeat (29) cycle();
        v = (req_log.size() > 1) ? 32'(req_log[1]) : 32'hFFFF_FFFF;
        check("start_next_addr", v, 32'h0001);
        check("dir_count", 32'(xfer_log.size() >= 9), 32'd1);
        if (xfer_log.size() >= 9)
            for (int k = 0; k < 9; k++) check("dir_seq", 32'(xfer_log[k]), 32'(exp_tab[k]));

        // backpressure fills exactly DEPTH words; suspend blocks refetch while draining
        for (int a = 0; a < 1024; a++) mem[a] = 16'h4321;
        do_reset();
        s_ready = 0; acks = 0;
        repeat (20) cycle();
        check("bp_words", 32'(acks), 32'd2);
        check("bp_idle", 32'(obs_req), 32'd0);
        s_susp = 1; s_ready = 1; x0 = xfers;
        repeat (20) cycle();
        check("susp_words", 32'(acks), 32'd2);
        check("susp_drain", 32'(xfers - x0), 32'd8);
        check("susp_idle", 32'(obs_req), 32'd0);
        s_susp = 0;
        repeat (10) cycle();
        check("resume", 32'(acks > 2), 32'd1);

        // jump while a request to 0x0010 is outstanding
        mem[16'h010] = 16'h7777; mem[16'h100] = 16'h4321;
        fixed_lat = 4; lat = 4;
        do_reset();
        s_ready = 0; s_jv = 1; s_ja = 16'h0010;
        cycle();
        s_jv = 0; found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            cycle();
            if (req_seen && req_addr_q == 16'h0010) found = 1;
        end
        check("jmp_req_0010", 32'(found), 32'd1);
        req_log.delete(); xfer_log.delete();
        s_jv = 1; s_ja = 16'h0100;
        cycle();
        s_jv = 0; s_ready = 1;
        repeat (30) cycle();
        v = (req_log.size() > 0) ? 32'(req_log[0]) : 32'hFFFF_FFFF;
        check("jmp_next_addr", v, 32'h0100);
        v = (xfer_log.size() > 0) ? 32'(xfer_log[0][18:0]) : 32'hFFFF_FFFF;
        check("jmp_first_pc", v, 32'({16'h0100, 3'd0}));

        // random traffic with latency, backpressure, suspend, jumps and resets
        fixed_lat = -1;
        for (int a = 0; a < 1024; a++) mem[a] = rand_word();
        do_reset();
        x0 = xfers;
        for (int c = 0; c < 4000; c++) begin
            s_ready = ($urandom_range(0, 3) != 0);
            s_susp  = ($urandom_range(0, 9) == 0);
            s_jv    = ($urandom_range(0, 49) == 0);
            s_ja    = 16'($urandom);
            s_rst   = ($urandom_range(0, 299) == 0);
            cycle();
        end
        check("rand_progress", 32'((xfers - x0) > 500), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
